// File: rtl/id_pkg.sv
// Shared opcode constants and decoded-instruction bundle for the decode stage.
package id_pkg;

    localparam int ID_INSTR_W     = 16;
    localparam int ID_OPCODE_W    = 4;
    localparam int ID_P_W         = (ID_INSTR_W - ID_OPCODE_W) / 2;
    localparam int ID_NUM_OPCODES = 13;

    localparam logic [ID_OPCODE_W-1:0] OP_NOP = 4'd0;
    localparam logic [ID_OPCODE_W-1:0] OP_1   = 4'd1;
    localparam logic [ID_OPCODE_W-1:0] OP_2   = 4'd2;
    localparam logic [ID_OPCODE_W-1:0] OP_3   = 4'd3;
    localparam logic [ID_OPCODE_W-1:0] OP_4   = 4'd4;
    localparam logic [ID_OPCODE_W-1:0] OP_5   = 4'd5;
    localparam logic [ID_OPCODE_W-1:0] OP_6   = 4'd6;
    localparam logic [ID_OPCODE_W-1:0] OP_7   = 4'd7;
    localparam logic [ID_OPCODE_W-1:0] OP_8   = 4'd8;
    localparam logic [ID_OPCODE_W-1:0] OP_9   = 4'd9;
    localparam logic [ID_OPCODE_W-1:0] OP_10  = 4'd10;
    localparam logic [ID_OPCODE_W-1:0] OP_11  = 4'd11;
    localparam logic [ID_OPCODE_W-1:0] OP_12  = 4'd12;

    typedef struct packed {
        logic [ID_OPCODE_W-1:0] opcode;
        logic [ID_P_W-1:0]      param1;
        logic [ID_P_W-1:0]      param2;
        logic                   illegal;
    } id_decoded_t;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_BUSY  = 2'b10,
        SB_FULL  = 2'b11
    } sb_state_t;

endpackage

// File: rtl/id_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready comes straight from a flop.
module id_skid_buf
    import id_pkg::*;
#(
    parameter type T = id_decoded_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    sb_state_t state_q, state_d;
    T          out_q, out_d;
    T          skid_q, skid_d;
    logic      in_xfer;
    logic      out_xfer;

    assign in_ready  = (state_q != SB_FULL);
    assign out_valid = state_q[1];
    assign out_data  = out_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            SB_EMPTY: begin
                if (in_xfer) begin
                    out_d   = in_data;
                    state_d = SB_BUSY;
                end
            end
            SB_BUSY: begin
                if (out_xfer && in_xfer) begin
                    out_d = in_data;
                end else if (out_xfer) begin
                    state_d = SB_EMPTY;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = SB_FULL;
                end
            end
            SB_FULL: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = SB_BUSY;
                end
            end
            default: state_d = SB_EMPTY;
        endcase
        // Flush drops everything in flight, including this cycle's offer
        if (flush) begin
            state_d = SB_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/id_decode_pipe.sv
// Instruction decode stage: field split, legality check, skid-buffered output.
// Optional perf counters enabled by defining ID_PERF_CNT_EN.
module id_decode_pipe
    import id_pkg::*;
#(
    parameter int INSTR_W     = ID_INSTR_W,
    parameter int OPCODE_W    = ID_OPCODE_W,
    parameter int NUM_OPCODES = ID_NUM_OPCODES,
`ifdef ID_PERF_CNT_EN
    parameter int CNT_W       = 16,
`endif
    localparam int P_W        = (INSTR_W - OPCODE_W) / 2
) (
    input  logic                ID_clock,
    input  logic                ID_reset,
    input  logic                ID_flush,
    input  logic                ID_in_valid,
    output logic                ID_in_ready,
    input  logic [INSTR_W-1:0]  ID_instruction,
    output logic                ID_out_valid,
    input  logic                ID_out_ready,
    output logic [OPCODE_W-1:0] ID_opcode,
    output logic [P_W-1:0]      ID_param1,
    output logic [P_W-1:0]      ID_param2,
`ifdef ID_PERF_CNT_EN
    output logic [CNT_W-1:0]    ID_cnt_decoded,
    output logic [CNT_W-1:0]    ID_cnt_illegal,
`endif
    output logic                ID_illegal
);

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [P_W-1:0]      param1;
        logic [P_W-1:0]      param2;
        logic                illegal;
    } dec_t;

    localparam logic [OPCODE_W:0] NUM_OP_L = NUM_OPCODES[OPCODE_W:0];

    dec_t                dec_in;
    dec_t                dec_out;
    logic [OPCODE_W-1:0] raw_op;

    assign raw_op = ID_instruction[INSTR_W-1 -: OPCODE_W];

    always_comb begin
        dec_in         = '0;
        dec_in.param1  = ID_instruction[INSTR_W-OPCODE_W-1 -: P_W];
        dec_in.param2  = ID_instruction[P_W-1:0];
        dec_in.illegal = ({1'b0, raw_op} >= NUM_OP_L);
        dec_in.opcode  = dec_in.illegal ? '0 : raw_op;
    end

    id_skid_buf #(
        .T(dec_t)
    ) u_skid (
        .clk      (ID_clock),
        .rst      (ID_reset),
        .flush    (ID_flush),
        .in_valid (ID_in_valid),
        .in_ready (ID_in_ready),
        .in_data  (dec_in),
        .out_valid(ID_out_valid),
        .out_ready(ID_out_ready),
        .out_data (dec_out)
    );

    assign ID_opcode  = dec_out.opcode;
    assign ID_param1  = dec_out.param1;
    assign ID_param2  = dec_out.param2;
    assign ID_illegal = dec_out.illegal;

`ifdef ID_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d;
    logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;
    logic             cnt_en;

    assign cnt_en = ID_out_valid && ID_out_ready && !ID_flush;

    always_comb begin
        cnt_dec_d = cnt_dec_q;
        cnt_ill_d = cnt_ill_q;
        // Saturate rather than wrap
        if (cnt_en && cnt_dec_q != '1) begin
            cnt_dec_d = cnt_dec_q + 1'b1;
        end
        if (cnt_en && dec_out.illegal && cnt_ill_q != '1) begin
            cnt_ill_d = cnt_ill_q + 1'b1;
        end
    end

    always_ff @(posedge ID_clock) begin
        if (ID_reset) begin
            cnt_dec_q <= '0;
            cnt_ill_q <= '0;
        end else begin
            cnt_dec_q <= cnt_dec_d;
            cnt_ill_q <= cnt_ill_d;
        end
    end

    assign ID_cnt_decoded = cnt_dec_q;
    assign ID_cnt_illegal = cnt_ill_q;
`endif

endmodule
